alu_exec_ctrl: RTL

// - Execute-stage ALU control: decodes alu_op/funct/opcode into a 4-bit ALU

---
 rtl/alu_exec_ctrl_pkg.sv | 63 ++++++
 rtl/alu_exec_ctrl_if.sv | 15 +
 rtl/alu_exec_ctrl_md_sequencer.sv | 39 +++
 rtl/alu_exec_ctrl.sv | 59 +++++
 4 files changed

// File: rtl/alu_exec_ctrl_pkg.sv
// alu_exec_ctrl_pkg: ALU/funct/opcode/mul-div codes, decode result type and the combinational decode function
package alu_exec_ctrl_pkg;
  localparam logic [3:0] ALU_AND  = 4'h0, ALU_OR   = 4'h1, ALU_ADD  = 4'h2, ALU_SLLV = 4'h3,
                         ALU_SRLV = 4'h4, ALU_SRAV = 4'h5, ALU_SUB  = 4'h6, ALU_SLT  = 4'h7,
                         ALU_SLTU = 4'h8, ALU_XOR  = 4'h9, ALU_NOR  = 4'hA, ALU_LUI  = 4'hB,
                         ALU_MFHI = 4'hC, ALU_MFLO = 4'hD, ALU_NOP  = 4'hF;
  localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07, F_MFHI = 6'h10,
                         F_MFLO = 6'h12, F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A,
                         F_DIVU = 6'h1B, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_NOR = 6'h27, F_SLT = 6'h2A, F_SLTU = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [1:0] MD_MULT = 2'b00, MD_MULTU = 2'b01, MD_DIV = 2'b10, MD_DIVU = 2'b11;
  typedef enum logic [1:0] {AOP_ADD, AOP_SUB, AOP_RTYPE, AOP_IMM} alu_op_e;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;
  typedef struct packed {
    logic [3:0] ctl;
    logic       ill;
    logic       md;
    logic [1:0] md_op;
  } dec_t;
  function automatic dec_t decode(input logic [1:0] alu_op, input logic [5:0] funct,
                                  input logic [5:0] imm_opc, input logic imm_en);
    dec_t d;
    d = '{ctl: ALU_NOP, ill: 1'b0, md: 1'b0, md_op: funct[1:0]};
    case (alu_op)
      AOP_ADD: d.ctl = ALU_ADD;
      AOP_SUB: d.ctl = ALU_SUB;
      AOP_RTYPE:
        case (funct)
          F_ADD, F_ADDU:                  d.ctl = ALU_ADD;
          F_SUB, F_SUBU:                  d.ctl = ALU_SUB;
          F_AND:                          d.ctl = ALU_AND;
          F_OR:                           d.ctl = ALU_OR;
          F_XOR:                          d.ctl = ALU_XOR;
          F_NOR:                          d.ctl = ALU_NOR;
          F_SLT:                          d.ctl = ALU_SLT;
          F_SLTU:                         d.ctl = ALU_SLTU;
          F_SLLV:                         d.ctl = ALU_SLLV;
          F_SRLV:                         d.ctl = ALU_SRLV;
          F_SRAV:                         d.ctl = ALU_SRAV;
          F_MFHI:                         d.ctl = ALU_MFHI;
          F_MFLO:                         d.ctl = ALU_MFLO;
          F_MULT, F_MULTU, F_DIV, F_DIVU: d.md  = 1'b1;
          default:                        d.ill = 1'b1;
        endcase
      default:
        if (imm_en)
          case (imm_opc)
            OP_ADDI, OP_ADDIU: d.ctl = ALU_ADD;
            OP_SLTI:           d.ctl = ALU_SLT;
            OP_SLTIU:          d.ctl = ALU_SLTU;
            OP_ANDI:           d.ctl = ALU_AND;
            OP_ORI:            d.ctl = ALU_OR;
            OP_XORI:           d.ctl = ALU_XOR;
            OP_LUI:            d.ctl = ALU_LUI;
            default:           d.ill = 1'b1;
          endcase
    endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: request (in_*), result (out_*, alu_control, illegal) and mul/div (md_*) signals; master drives requests, slave is the controller
interface alu_exec_ctrl_if #(parameter int CTRL_W = 4);
  logic              in_valid, in_ready;
  logic [1:0]        alu_op;
  logic [5:0]        funct, imm_opc;
  logic              out_valid, out_ready;
  logic [CTRL_W-1:0] alu_control;
  logic              illegal, md_start;
  logic [1:0]        md_op;
  logic              md_busy, md_done;
  modport master (output in_valid, alu_op, funct, imm_opc, out_ready,
                  input in_ready, out_valid, alu_control, illegal, md_start, md_op, md_busy, md_done);
  modport slave  (input in_valid, alu_op, funct, imm_opc, out_ready,
                  output in_ready, out_valid, alu_control, illegal, md_start, md_op, md_busy, md_done);
endinterface

// File: rtl/alu_exec_ctrl_md_sequencer.sv
// md_sequencer: mul/div occupancy FSM; in clk, rst, launch_i; out busy_o (in BUSY), done_o (last BUSY cycle)
module md_sequencer
  import alu_exec_ctrl_pkg::*;
#(parameter int MD_CYCLES = 32) (
  input  logic clk,
  input  logic rst,
  input  logic launch_i,
  output logic busy_o,
  output logic done_o
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);
  md_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    busy_o  = state_q == MD_BUSY;
    done_o  = busy_o & (cnt_q == LAST);
    state_d = state_q;
    cnt_d   = cnt_q;
    if (launch_i & (~busy_o | done_o)) begin
      state_d = MD_BUSY;
      cnt_d   = '0;
    end else if (done_o) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end else if (busy_o) begin
      cnt_d   = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: registered ALU-control decode with valid/ready handshake and HI/LO interlock; ports clk, rst, bus_io (slave: in_*, out_*, alu_control, illegal, md_*)
module alu_exec_ctrl
  import alu_exec_ctrl_pkg::*;
#(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter bit IMM_EN    = 1'b1
) (
  input logic clk,
  input logic rst,
  alu_exec_ctrl_if.slave bus_io
);
  dec_t dec;
  logic hilo_user, accept, launch, busy, done;
  logic out_valid_q, out_valid_d, ill_q, ill_d, md_start_q, md_start_d;
  logic [CTRL_W-1:0] ctl_q, ctl_d;
  logic [1:0] md_op_q, md_op_d;
  always_comb begin
    dec             = decode(bus_io.alu_op, bus_io.funct, bus_io.imm_opc, IMM_EN);
    hilo_user       = dec.md | (dec.ctl == ALU_MFHI) | (dec.ctl == ALU_MFLO);
    bus_io.in_ready = (~out_valid_q | bus_io.out_ready) & ~(hilo_user & busy & ~done);
    accept          = bus_io.in_valid & bus_io.in_ready;
    launch          = accept & dec.md;
    out_valid_d     = accept | (out_valid_q & ~bus_io.out_ready);
    ctl_d           = accept ? CTRL_W'(dec.ctl) : ctl_q;
    ill_d           = accept ? dec.ill : ill_q;
    md_op_d         = launch ? dec.md_op : md_op_q;
    md_start_d      = launch;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctl_q       <= CTRL_W'(ALU_NOP);
      ill_q       <= 1'b0;
      md_op_q     <= 2'b00;
      md_start_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      ctl_q       <= ctl_d;
      ill_q       <= ill_d;
      md_op_q     <= md_op_d;
      md_start_q  <= md_start_d;
    end
  end
  md_sequencer #(.MD_CYCLES(MD_CYCLES)) u_seq (
    .clk      (clk),
    .rst      (rst),
    .launch_i (launch),
    .busy_o   (busy),
    .done_o   (done)
  );
  assign bus_io.out_valid   = out_valid_q;
  assign bus_io.alu_control = ctl_q;
  assign bus_io.illegal     = ill_q;
  assign bus_io.md_start    = md_start_q;
  assign bus_io.md_op       = md_op_q;
  assign bus_io.md_busy     = busy;
  assign bus_io.md_done     = done;
endmodule
